data_stack_memory: RTL and testbench
====================================

Name: data_stack_memory

Overview:
- Parametrised successor to the processor's combined data-RAM/stack memory.
- Provides a separate RAM region with addressed read/write and a hardware-managed stack with an internal stack pointer (push/pop).
- Adds a request/ready handshake, registered read data with a valid strobe, full/empty flags, and sticky fault reporting with a FAULT state.
- Sits between the core's memory-stage control and the register write-back path.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, width of the Addr port.
- RAM_DEPTH, 128, number of RAM words; must be a power of 2, at least 2.
- STK_DEPTH, 128, number of stack words; must be a power of 2, at least 2.
- SP_W, $clog2(STK_DEPTH)+1, stack pointer width, sized to hold 0..STK_DEPTH.

Ports:
- Clock, in, 1, single clock; all state updates on the rising edge.
- ResetN, in, 1, reset; asynchronous, active-low.
- Req, in, 1, request valid; accepted on a rising edge when Req=1 and Ready=1.
- Op, in, 2, operation: 00 RAM read, 01 RAM write, 10 push, 11 pop.
- Addr, in, ADDR_W, RAM word address; ignored for push and pop.
- DataIn, in, DATA_W, write or push data.
- Ready, out, 1, block can accept a request.
- DataOut, out, DATA_W, registered read or pop data.
- DataValid, out, 1, one-cycle strobe qualifying DataOut.
- StackPointer, out, SP_W, number of words currently on the stack.
- StkFull, out, 1, high when StackPointer == STK_DEPTH.
- StkEmpty, out, 1, high when StackPointer == 0.
- Fault, out, 1, sticky fault indicator.
- FaultCode, out, 2, 00 none, 01 overflow, 10 underflow, 11 RAM address out of range.
- FaultClear, in, 1, clears the fault and returns the block to IDLE.

Behaviour:
- Reset values (ResetN=0, asynchronous):
  - state=IDLE, StackPointer=0, DataOut=0, DataValid=0.
  - Fault=0, FaultCode=00, Ready=0 while reset is held.
  - RAM and stack contents are not reset.
- States: IDLE and FAULT.
  - Ready=1 in IDLE.
  - Ready=0 in FAULT.
- Accepted RAM read (Op=00), Addr < RAM_DEPTH:
  - Next edge: DataOut=RAM[Addr], DataValid=1 for exactly one cycle.
  - Latency is 1; back-to-back reads give one result per cycle.
- Accepted RAM write (Op=01), Addr < RAM_DEPTH:
  - RAM[Addr]<=DataIn. DataValid stays 0.
- Read-after-write to the same address in the next cycle returns the new data.
  - A read issued in the same cycle as a write is impossible: there is one request per cycle.
- Accepted push (Op=10), not full:
  - Stack[SP]<=DataIn, SP<=SP+1.
- Accepted pop (Op=11), not empty:
  - DataOut<=Stack[SP-1], SP<=SP-1, DataValid=1 next cycle.
- Addressing: only the low $clog2(RAM_DEPTH) bits index the RAM.
  - Any Addr >= RAM_DEPTH with Op 00/01 is a fault (FaultCode=11).
  - No write occurs, memory is unchanged, and DataValid stays 0.
- Push when full: FaultCode=01; no write, SP unchanged.
- Pop when empty: FaultCode=10; SP unchanged, DataValid stays 0.
- On any fault:
  - Fault=1 and state=FAULT from the next edge.
  - Fault and FaultCode hold; requests are ignored while in FAULT.
- FaultClear=1 in FAULT:
  - Next edge: Fault=0, FaultCode=00, state=IDLE, Ready=1.
  - SP and memory contents are preserved.
  - A Req in the same cycle is not accepted, because Ready=0.
- FaultClear in IDLE has no effect.
- DataOut holds its last value when DataValid=0.
- StkFull and StkEmpty are combinational decodes of the SP register.
- Reset asserted mid-operation:
  - Any in-flight DataValid is dropped.
  - SP returns to 0 (stack logically emptied); state=IDLE after release.
- Arithmetic: SP never wraps; the overflow and underflow checks prevent wrap.

Test Plan:
- Reset, then write RAM[5]=0xDEADBEEF, then read Addr=5 -> next cycle DataOut=0xDEADBEEF, DataValid high for exactly one cycle, Ready=1 throughout.
- Push 0x11, 0x22, 0x33, then pop three times -> DataOut sequence 0x33, 0x22, 0x11 on consecutive valid strobes. SP goes 3 -> 0 and StkEmpty=1 at the end.
- Push STK_DEPTH words, then push 0x99 -> StkFull=1, Fault=1, FaultCode=01, Ready=0, SP=STK_DEPTH. Assert FaultClear -> Ready=1. Then pop -> returns the last word pushed before overflow, not 0x99.
- Pop from empty after reset -> FaultCode=10, DataValid stays 0, SP=0. A Req during FAULT (write RAM[0]=0x1) is ignored: after FaultClear, reading RAM[0] shows the old value.
- Write to Addr=RAM_DEPTH (128) -> FaultCode=11 and no RAM word changes. Check RAM[0] is unchanged to catch aliasing.
- Push 3 words, then assert ResetN=0 in the cycle after a pop is accepted -> DataValid=0, SP=0, StkEmpty=1. After release, Ready=1.

Source files
------------

// File: rtl/data_stack_memory_if.sv
// Request/response bundle for data_stack_memory.
//   master: Req, Op, Addr, DataIn, FaultClear  -> block
//   slave : Ready, DataOut, DataValid, StackPointer, StkFull, StkEmpty,
//           Fault, FaultCode                    -> core
// Parameters must match the ones given to the attached data_stack_memory.
interface data_stack_memory_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int STK_DEPTH = 128,
  parameter int SP_W      = $clog2(STK_DEPTH) + 1
);
  logic              Req;
  logic [1:0]        Op;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] DataIn;
  logic              FaultClear;
  logic              Ready;
  logic [DATA_W-1:0] DataOut;
  logic              DataValid;
  logic [SP_W-1:0]   StackPointer;
  logic              StkFull;
  logic              StkEmpty;
  logic              Fault;
  logic [1:0]        FaultCode;

  modport master (
    output Req, Op, Addr, DataIn, FaultClear,
    input  Ready, DataOut, DataValid, StackPointer, StkFull, StkEmpty, Fault, FaultCode
  );

  modport slave (
    input  Req, Op, Addr, DataIn, FaultClear,
    output Ready, DataOut, DataValid, StackPointer, StkFull, StkEmpty, Fault, FaultCode
  );
endinterface

// File: rtl/data_stack_memory.sv
// Combined data RAM + hardware stack for the memory stage.
//   Clock, ResetN : clock, async active-low reset
//   bus (slave)   : Req/Op/Addr/DataIn/FaultClear in;
//                   Ready, DataOut/DataValid (1-cycle read/pop latency),
//                   StackPointer, StkFull/StkEmpty, sticky Fault/FaultCode out.
// Op: 00 RAM read, 01 RAM write, 10 push, 11 pop. Any illegal access
// (overflow, underflow, RAM address out of range) parks the block in FAULT
// until FaultClear; state other than the fault flags is preserved.
module data_stack_memory #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int RAM_DEPTH = 128,
  parameter int STK_DEPTH = 128,
  parameter int SP_W      = $clog2(STK_DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              ResetN,
  data_stack_memory_if.slave bus
);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int STK_AW = $clog2(STK_DEPTH);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_OVER  = 2'b01;
  localparam logic [1:0] FC_UNDER = 2'b10;
  localparam logic [1:0] FC_ADDR  = 2'b11;

  typedef enum logic {IDLE, FAULT} state_t;

  state_t            state;
  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [DATA_W-1:0] stk [STK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [DATA_W-1:0] dataOut;
  logic              dataValid;
  logic              fault;
  logic [1:0]        faultCode;

  logic              accept, addrOk, full, empty;
  logic [RAM_AW-1:0] ramIdx;
  logic [STK_AW-1:0] pushIdx, popIdx;

  // Ready is gated by ResetN so it reads 0 for the whole reset window.
  assign bus.Ready = ResetN && (state == IDLE);
  assign accept    = bus.Req && bus.Ready;

  // Any set bit above the RAM index range means out of range; the low bits
  // alone would silently alias onto a valid word.
  assign addrOk  = (bus.Addr >> RAM_AW) == '0;
  assign ramIdx  = bus.Addr[RAM_AW-1:0];
  assign full    = (sp == SP_W'(STK_DEPTH));
  assign empty   = (sp == '0);
  assign pushIdx = sp[STK_AW-1:0];
  assign popIdx  = sp[STK_AW-1:0] - STK_AW'(1);

  // Storage arrays: no reset so they map onto memory macros.
  always_ff @(posedge Clock) begin
    if (accept && bus.Op == OP_WRITE && addrOk) ram[ramIdx]  <= bus.DataIn;
    if (accept && bus.Op == OP_PUSH && !full)   stk[pushIdx] <= bus.DataIn;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      sp        <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      fault     <= 1'b0;
      faultCode <= FC_NONE;
    end else begin
      dataValid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          case (bus.Op)
            OP_READ: if (addrOk) begin
              dataOut   <= ram[ramIdx];
              dataValid <= 1'b1;
            end else begin
              state <= FAULT; fault <= 1'b1; faultCode <= FC_ADDR;
            end
            OP_WRITE: if (!addrOk) begin
              state <= FAULT; fault <= 1'b1; faultCode <= FC_ADDR;
            end
            OP_PUSH: if (full) begin
              state <= FAULT; fault <= 1'b1; faultCode <= FC_OVER;
            end else begin
              sp <= sp + SP_W'(1);
            end
            default: if (empty) begin  // OP_POP
              state <= FAULT; fault <= 1'b1; faultCode <= FC_UNDER;
            end else begin
              dataOut   <= stk[popIdx];
              dataValid <= 1'b1;
              sp        <= sp - SP_W'(1);
            end
          endcase
        end
        default: if (bus.FaultClear) begin  // FAULT: requests ignored
          state     <= IDLE;
          fault     <= 1'b0;
          faultCode <= FC_NONE;
        end
      endcase
    end
  end

  assign bus.DataOut      = dataOut;
  assign bus.DataValid    = dataValid;
  assign bus.StackPointer = sp;
  assign bus.StkFull      = full;
  assign bus.StkEmpty     = empty;
  assign bus.Fault        = fault;
  assign bus.FaultCode    = faultCode;
endmodule

// File: tb/tb_data_stack_memory.sv
module tb_data_stack_memory;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int RAM_DEPTH = 128;
  localparam int STK_DEPTH = 128;
  localparam int SP_W      = $clog2(STK_DEPTH) + 1;
  localparam int AW        = $clog2(RAM_DEPTH);

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, PU = 2'b10, PO = 2'b11;

  logic Clock  = 1'b0;
  logic ResetN = 1'b1;
  always #5 Clock = ~Clock;

  data_stack_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STK_DEPTH(STK_DEPTH), .SP_W(SP_W)) bus ();

  data_stack_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH),
    .STK_DEPTH(STK_DEPTH), .SP_W(SP_W)
  ) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .bus   (bus)
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: RAM array, stack as a queue, fault as a flag + code.
  logic [DATA_W-1:0] mRam [RAM_DEPTH];
  logic [DATA_W-1:0] mStk [$];
  bit                mFault = 0;
  logic [1:0]        mCode  = 2'b00;
  logic [DATA_W-1:0] mOut   = '0;
  bit                mValid = 0;

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      mStk.delete();
      mFault = 0; mCode = 2'b00; mOut = '0; mValid = 0;
    end else begin
      mValid = 0;
      if (mFault) begin
        if (bus.FaultClear) begin mFault = 0; mCode = 2'b00; end
      end else if (bus.Req) begin
        case (bus.Op)
          RD: if (bus.Addr < RAM_DEPTH) begin mOut = mRam[bus.Addr[AW-1:0]]; mValid = 1; end
              else begin mFault = 1; mCode = 2'b11; end
          WR: if (bus.Addr < RAM_DEPTH) mRam[bus.Addr[AW-1:0]] = bus.DataIn;
              else begin mFault = 1; mCode = 2'b11; end
          PU: if (mStk.size() == STK_DEPTH) begin mFault = 1; mCode = 2'b01; end
              else mStk.push_back(bus.DataIn);
          default: if (mStk.size() == 0) begin mFault = 1; mCode = 2'b10; end
                   else begin mOut = mStk.pop_back(); mValid = 1; end
        endcase
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge Clock) begin
    chk("Ready",     64'(bus.Ready),        64'(ResetN && !mFault));
    chk("DataValid", 64'(bus.DataValid),    64'(mValid));
    chk("DataOut",   64'(bus.DataOut),      64'(mOut));
    chk("SP",        64'(bus.StackPointer), 64'(mStk.size()));
    chk("StkFull",   64'(bus.StkFull),      64'(mStk.size() == STK_DEPTH));
    chk("StkEmpty",  64'(bus.StkEmpty),     64'(mStk.size() == 0));
    chk("Fault",     64'(bus.Fault),        64'(mFault));
    chk("FaultCode", 64'(bus.FaultCode),    64'(mCode));
  end

  task automatic cyc();
    @(posedge Clock); #1;
  endtask

  task automatic req(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
    bus.Req = 1'b1; bus.Op = op; bus.Addr = addr; bus.DataIn = d;
    cyc();
    bus.Req = 1'b0;
  endtask

  task automatic clearFault();
    bus.FaultClear = 1'b1;
    cyc();
    bus.FaultClear = 1'b0;
  endtask

  task automatic doReset();
    ResetN = 1'b0;
    cyc(); cyc();
    ResetN = 1'b1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.Req = 1'b0; bus.Op = RD; bus.Addr = '0; bus.DataIn = '0; bus.FaultClear = 1'b0;
    #1 ResetN = 1'b0;
    #1 chk("rst Ready", 64'(bus.Ready), 64'(0));
    chk("rst DataOut", 64'(bus.DataOut), 64'(0));
    chk("rst SP", 64'(bus.StackPointer), 64'(0));
    repeat (2) @(posedge Clock);
    #1 ResetN = 1'b1;
    cyc();
    chk("post rst Ready", 64'(bus.Ready), 64'(1));

    // Write then read RAM[5]
    req(WR, 5, 32'hDEADBEEF);
    chk("wr DataValid", 64'(bus.DataValid), 64'(0));
    req(RD, 5, '0);
    chk("rd5 data", 64'(bus.DataOut), 64'h0000_0000_DEAD_BEEF);
    chk("rd5 valid", 64'(bus.DataValid), 64'(1));
    cyc();
    chk("rd5 strobe 1 cycle", 64'(bus.DataValid), 64'(0));
    // FaultClear in IDLE has no effect
    clearFault();
    chk("clr idle Ready", 64'(bus.Ready), 64'(1));

    // LIFO order
    req(PU, 0, 32'h11); req(PU, 0, 32'h22); req(PU, 0, 32'h33);
    chk("sp3", 64'(bus.StackPointer), 64'(3));
    req(PO, 0, '0); chk("pop1", 64'(bus.DataOut), 64'h33); chk("pop1 sp", 64'(bus.StackPointer), 64'(2));
    req(PO, 0, '0); chk("pop2", 64'(bus.DataOut), 64'h22);
    req(PO, 0, '0); chk("pop3", 64'(bus.DataOut), 64'h11); chk("pop3 valid", 64'(bus.DataValid), 64'(1));
    chk("empty", 64'(bus.StkEmpty), 64'(1));

    // Overflow
    for (int i = 0; i < STK_DEPTH; i++) req(PU, 0, DATA_W'(32'h100 + i));
    chk("full", 64'(bus.StkFull), 64'(1));
    req(PU, 0, 32'h99);
    chk("ovf Fault", 64'(bus.Fault), 64'(1));
    chk("ovf code", 64'(bus.FaultCode), 64'(1));
    chk("ovf Ready", 64'(bus.Ready), 64'(0));
    chk("ovf SP", 64'(bus.StackPointer), 64'(STK_DEPTH));
    clearFault();
    chk("ovf clr Ready", 64'(bus.Ready), 64'(1));
    chk("ovf clr code", 64'(bus.FaultCode), 64'(0));
    req(PO, 0, '0);
    chk("ovf pop data", 64'(bus.DataOut), 64'h17F);

    // Underflow; request during FAULT is dropped
    req(WR, 0, 32'hA5A5);
    doReset();
    req(PO, 0, '0);
    chk("udf code", 64'(bus.FaultCode), 64'(2));
    chk("udf valid", 64'(bus.DataValid), 64'(0));
    chk("udf SP", 64'(bus.StackPointer), 64'(0));
    req(WR, 0, 32'h1);
    chk("fault hold", 64'(bus.FaultCode), 64'(2));
    clearFault();
    req(RD, 0, '0);
    chk("ram0 kept", 64'(bus.DataOut), 64'hA5A5);

    // Out-of-range write must not alias onto RAM[0]
    req(WR, ADDR_W'(RAM_DEPTH), 32'hBAD);
    chk("addr code", 64'(bus.FaultCode), 64'(3));
    clearFault();
    req(RD, 0, '0);
    chk("alias ram0", 64'(bus.DataOut), 64'hA5A5);
    req(RD, 5, '0);
    chk("b2b ram5", 64'(bus.DataOut), 64'hDEADBEEF);
    chk("b2b valid", 64'(bus.DataValid), 64'(1));
    req(RD, 32'h8000_0000, '0);
    chk("addr hi code", 64'(bus.FaultCode), 64'(3));
    clearFault();

    // Reset right after a pop is accepted
    req(PU, 0, 32'h1); req(PU, 0, 32'h2); req(PU, 0, 32'h3);
    req(PO, 0, '0);
    chk("pre rst valid", 64'(bus.DataValid), 64'(1));
    ResetN = 1'b0;
    #1;
    chk("mid rst valid", 64'(bus.DataValid), 64'(0));
    chk("mid rst SP", 64'(bus.StackPointer), 64'(0));
    chk("mid rst empty", 64'(bus.StkEmpty), 64'(1));
    cyc();
    ResetN = 1'b1;
    cyc();
    chk("rel Ready", 64'(bus.Ready), 64'(1));
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
